imm_ext_pipe: RTL and testbench

Registered, flow-controlled immediate generator for the decode stage. It accepts instruction words with a format select and emits the sign- or zero-extended immediate one cycle later. Widths are XLEN-parametrised, and the block adds U-type and CSR zimm formats. A 2-entry skid buffer sits between fetch/decode and the issue logic, so back-pressure never drops or duplicates an instruction.

---
 rtl/imm_pkg.sv | 27 ++
 rtl/imm_decode.sv | 36 +++
 rtl/imm_ext_pipe.sv | 117 +++++++++++
 tb/tb_imm_ext_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types and constants for the immediate generator pipe
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    IMM_Z = 3'b101
  } imm_src_t;

  localparam int XLEN_RV32 = 32;
  localparam int XLEN_RV64 = 64;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == XLEN_RV32) || (xlen == XLEN_RV64);
  endfunction

  // Encoding is {out_v, skid_v}, so the state register doubles as the valid bits
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b10,
    FULL  = 2'b11
  } pipe_state_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate extractor and XLEN extender
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic [31:0] raw;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  // Every format is first formed as a sign-correct 32-bit value; Z and U-low
  // have a clear bit 31 where appropriate, so one sign extension covers all.
  always_comb begin
    raw = '0;
    err = 1'b0;
    case (imm_src)
      IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   raw = {instr[31:12], 12'b0};
      IMM_Z:   raw = {27'b0, instr[19:15]};
      default: err = 1'b1;
    endcase
  end

  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - registered immediate generator with 2-entry skid buffer
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  if (!xlen_legal(XLEN)) begin : g_xlen_check
    $error("imm_ext_pipe: XLEN must be 32 or 64");
  end

  pipe_state_t      state_q, state_d;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_err;
  logic             accept, drain;
  logic             load_out_in, load_out_skid, load_skid;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm_src (in_imm_src),
    .imm     (dec_imm),
    .err     (dec_err)
  );

  assign out_valid = state_q[1];
  assign in_ready  = !state_q[0];
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            load_out_in = 1'b1;
            state_d     = BUSY;
          end
        end
        BUSY: begin
          if (accept && drain) begin
            load_out_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            load_out_skid = 1'b1;
            state_d       = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_imm <= '0;
      out_tag <= '0;
      out_err <= 1'b0;
    end else if (load_out_in) begin
      out_imm <= dec_imm;
      out_tag <= in_tag;
      out_err <= dec_err;
    end else if (load_out_skid) begin
      out_imm <= skid_imm;
      out_tag <= skid_tag;
      out_err <= skid_err;
    end
  end

  // Skid payload is only ever read while skid_v is set, so it carries no reset
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_imm <= dec_imm;
      skid_tag <= in_tag;
      skid_err <= dec_err;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - self-checking bench for imm_ext_pipe at XLEN 32 and 64
module tb_imm_ext_pipe;

  localparam int TAG_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      in_instr = '0;
  logic [2:0]       in_imm_src = '0;
  logic [TAG_W-1:0] in_tag = '0;

  logic             in_ready, in_ready64;
  logic             out_valid, out_valid64;
  logic [31:0]      out_imm;
  logic [63:0]      out_imm64;
  logic [TAG_W-1:0] out_tag, out_tag64;
  logic             out_err, out_err64;

  imm_ext_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_tag(out_tag), .out_err(out_err)
  );

  imm_ext_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_err(out_err64)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0]      e32;
    logic [63:0]      e64;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               acc;
    bit               lat;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
  } vec_t;

  exp_t sb[$];
  exp_t mon_cur;
  bit   front_seen = 1'b0;
  vec_t vecs[13];

  // Scoreboard consumer: peek while stalled (hold check), pop on transfer
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid) begin
      if (sb.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_output: got out_valid=1 tag 0x%0h, expected no entry", out_tag);
      end else begin
        mon_cur = sb[0];
        chk("imm32", {32'b0, out_imm}, {32'b0, mon_cur.e32});
        chk("imm64", out_imm64, mon_cur.e64);
        chk("tag", out_tag, mon_cur.tag);
        chk("tag64", out_tag64, mon_cur.tag);
        chk("err", out_err, mon_cur.err);
        chk("err64", out_err64, mon_cur.err);
        if (mon_cur.lat && !front_seen) chk("latency", cyc, mon_cur.acc + 1);
        front_seen = 1'b1;
        if (out_ready) begin
          sb.delete(0);
          front_seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [2:0] src, input logic [31:0] tag,
                      input logic [31:0] e32, input logic [63:0] e64, input logic err, input bit lat);
    exp_t e;
    bit   done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_instr = instr; in_imm_src = src; in_tag = tag;
      if (in_ready) begin
        e.e32 = e32; e.e64 = e64; e.tag = tag; e.err = err; e.acc = cyc; e.lat = lat;
        sb.push_back(e);
        done = 1'b1;
      end
    end
    chk("send_accepted", {63'b0, done}, 64'd1);
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int t = 0; t < 60 && sb.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    chk(name, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{32'hFE20AE23, 3'b001, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2]  = '{32'h001000EF, 3'b011, 32'h00000800, 64'h0000000000000800, 1'b0};
    vecs[3]  = '{32'h123452B7, 3'b100, 32'h12345000, 64'h0000000012345000, 1'b0};
    vecs[4]  = '{32'h000F8073, 3'b101, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vecs[5]  = '{32'h800002B7, 3'b100, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vecs[6]  = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[7]  = '{32'h00000463, 3'b010, 32'h00000008, 64'h0000000000000008, 1'b0};
    vecs[8]  = '{32'h7FF00093, 3'b000, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    vecs[9]  = '{32'h800F8073, 3'b101, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vecs[10] = '{32'hFFFFFFFF, 3'b110, 32'h00000000, 64'h0000000000000000, 1'b1};
    vecs[11] = '{32'hFFFFFFFF, 3'b111, 32'h00000000, 64'h0000000000000000, 1'b1};
    vecs[12] = '{32'h00500093, 3'b000, 32'h00000005, 64'h0000000000000005, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_imm", out_imm64, 64'd0);
    chk("rst_out_tag", out_tag, 64'd0);
    chk("rst_out_err", {63'b0, out_err}, 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Format table, streamed back-to-back with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++)
      send(vecs[i].instr, vecs[i].src, 32'h100 + i, vecs[i].e32, vecs[i].e64, vecs[i].err, 1'b1);
    idle_in();
    wait_empty("fmt_drained");

    // Back-pressure: out_ready low for 3 cycles while tags 1..4 stream in
    begin
      exp_t e;
      int   idx = 0;
      for (int k = 0; k < 30 && idx < 4; k++) begin
        @(posedge clk); #1;
        out_ready = (k >= 3);
        if (k == 2) chk("bp_in_ready_full", {63'b0, in_ready}, 64'd0);
        in_valid = 1'b1;
        in_imm_src = 3'b000;
        in_tag = idx + 1;
        in_instr = {12'(idx + 1), 20'h00093};
        if (in_ready) begin
          e.e32 = idx + 1; e.e64 = idx + 1; e.tag = idx + 1; e.err = 1'b0;
          e.acc = cyc; e.lat = 1'b0;
          sb.push_back(e);
          idx++;
        end
      end
      chk("bp_all_accepted", idx, 4);
    end
    idle_in();
    wait_empty("bp_drained");

    // Flush while FULL with a simultaneous in_valid entry
    out_ready = 1'b0;
    send(32'h00100093, 3'b000, 32'h10, 32'h1, 64'h1, 1'b0, 1'b0);
    send(32'h00200093, 3'b000, 32'h11, 32'h2, 64'h2, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("full_in_ready", {63'b0, in_ready}, 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_tag = 32'h99; in_instr = 32'h00900093;
    sb.delete(); front_seen = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_out_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_full_in_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("flush_full_quiet", {63'b0, out_valid}, 64'd0);
    end

    // Flush in BUSY while an entry is being accepted
    out_ready = 1'b0;
    send(32'h00300093, 3'b000, 32'h12, 32'h3, 64'h3, 1'b0, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_tag = 32'h98; in_instr = 32'h00800093;
    sb.delete(); front_seen = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("flush_busy_quiet", {63'b0, out_valid}, 64'd0);
      @(posedge clk); #1;
    end

    // Asynchronous reset between edges, mid-stream
    out_ready = 1'b0;
    send(32'hFFF00093, 3'b000, 32'h20, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
    send(32'h00700093, 3'b000, 32'h21, 32'h7, 64'h7, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_out_imm", {32'b0, out_imm}, 64'd0);
    chk("arst_out_imm64", out_imm64, 64'd0);
    chk("arst_out_tag", out_tag, 64'd0);
    chk("arst_out_err", {63'b0, out_err}, 64'd0);
    chk("arst_in_ready", {63'b0, in_ready}, 64'd1);
    sb.delete(); front_seen = 1'b0;
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'h123452B7, 3'b100, 32'h30, 32'h12345000, 64'h12345000, 1'b0, 1'b1);
    idle_in();
    wait_empty("arst_drained");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
